phase_rom_arbiter: RTL and testbench
====================================

Name: phase_rom_arbiter

Overview:
- Shares one controlled-phase coefficient ROM pair between NUM_REQ requesters (real part and imaginary part, R(k) stored at address k-2) across the non-stabilizer gate lanes.
- Each requester asks for rotation R(k) with an optional conjugate flag.
- The block arbitrates round-robin, drives the ROM address, and captures the registered ROM output.
- It returns the complex coefficient through a valid/ready response port. At most one fetch is in flight at a time.

Parameters:
- NUM_REQ, 4, number of requesters; must be at least 2.
- DATA_WIDTH, 24, width of a ROM word; two's complement; 1.0 = 2^(DATA_WIDTH-2).
- ADDR_WIDTH, 5, ROM address width.
- K_WIDTH, 6, width of the rotation index k.
- ID_WIDTH, 2, requester id width; must satisfy 2^ID_WIDTH >= NUM_REQ.

Ports:
- clk  in  1  sole clock; all logic on posedge.
- nreset  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant; one-hot or zero.
- req_k  in  NUM_REQ*K_WIDTH  packed rotation index; requester i uses slice i.
- req_inv  in  NUM_REQ  per-requester conjugate flag.
- rom_addr  out  ADDR_WIDTH  registered address to both ROMs.
- rom_re_q  in  DATA_WIDTH  real ROM output; registered inside the ROM with 1-cycle latency.
- rom_im_q  in  DATA_WIDTH  imaginary ROM output; same timing as rom_re_q.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response accept.
- resp_id  out  ID_WIDTH  id of the requester being answered.
- resp_re  out  DATA_WIDTH  real part of the result.
- resp_im  out  DATA_WIDTH  imaginary part of the result.
- resp_err  out  1  set when k is out of range (see below).

Behaviour:
- Reset (async assert, nreset=0):
  - state=IDLE; rr_ptr=NUM_REQ-1, so requester 0 has first priority.
  - rom_addr=0; resp_valid=0; resp_id=0; resp_re=0; resp_im=0; resp_err=0.
  - req_ready=0 while in reset.
  - Reset mid-operation abandons the fetch; no response is produced for it.
- States and transitions:
  - IDLE: req_ready is combinational, granting the first valid requester scanning from rr_ptr+1 upward with wrap. Handshake = req_valid[i] & req_ready[i] at a posedge. On handshake: latch id, k, inv; rr_ptr<=i; rom_addr<=k-2 (low ADDR_WIDTH bits, 0 if k<2); go to FETCH. No request: stay in IDLE.
  - FETCH: the ROM samples rom_addr. Go to CAPTURE next edge.
  - CAPTURE: on the edge leaving CAPTURE, load the response registers. Set resp_valid<=1 and go to RESP.
  - RESP: hold all resp_* stable while resp_valid=1 and resp_ready=0. On resp_valid & resp_ready: resp_valid<=0 and go to IDLE. req_ready=0 in every state except IDLE.
- Latency and throughput:
  - resp_valid is high in the 3rd cycle after the handshake edge; fixed for every k.
  - If resp_ready is held high, a new grant is possible at the earliest in the cycle after the accept. Maximum rate is one transaction per 4 cycles.
- Result selection (applied at CAPTURE):
  - k=0: (ONE, 0).
  - k=1: (-ONE, 0).
  - 2 <= k <= 2^ADDR_WIDTH+1: (rom_re_q, rom_im_q).
  - k > 2^ADDR_WIDTH+1: (ONE, 0) with resp_err=1. The angle is treated as negligible.
  - resp_err=0 in all other cases.
- Conjugate: if inv=1, resp_im = -im in two's complement. If im is the most-negative value, the result saturates to the most-positive value. -0 = 0.
- Arbitration fairness:
  - rr_ptr changes only on a handshake.
  - Requests arriving while busy wait; there is no queueing beyond the requester's own valid.
  - A requester must hold req_valid, req_k and req_inv stable until its grant.
  - Dropping req_valid before the grant is legal; no grant results.

Test Plan:
- Single request: req_valid[0]=1, k=2, inv=0, ROM[0]=(0x000000, 0x400000) -> resp in 3rd cycle after handshake; resp_id=0, re=0x000000, im=0x400000, err=0.
- Conjugate: k=3, inv=1, ROM[1]=(0x2D413D, 0x2D413D) -> re=0x2D413D, im=0xD2BEC3.
- Special and error cases (DATA_WIDTH=24, ADDR_WIDTH=5):
  - k=0 -> (0x400000, 0).
  - k=1 -> (0xC00000, 0); rom_addr=0 for both.
  - k=34 -> (0x400000, 0), err=1.
- Round-robin: all 4 requesters valid continuously, resp_ready=1 -> grant order 0,1,2,3,0 with one response per 4 cycles.
- Backpressure: resp_ready=0 for 10 cycles after resp_valid -> resp_* stable, req_ready all zero. resp_ready=1 -> next grant is issued in the following cycle.
- Reset in FETCH: nreset low for 1 cycle -> resp_valid=0 and no response. The next request after reset is granted to the lowest-index valid requester.

Source files
------------

// File: rtl/phase_rom_arbiter.sv
// Round-robin arbiter sharing one registered coefficient ROM pair between requesters.
// Returns R(k) (optionally conjugated) through a valid/ready response port, one fetch at a time.
module phase_rom_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 24,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned K_WIDTH    = 6,
   parameter int unsigned ID_WIDTH   = 2
) (
   input  logic                         clk,
   input  logic                         nreset,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ*K_WIDTH-1:0]   req_k,
   input  logic [NUM_REQ-1:0]           req_inv,
   output logic [ADDR_WIDTH-1:0]        rom_addr,
   input  logic [DATA_WIDTH-1:0]        rom_re_q,
   input  logic [DATA_WIDTH-1:0]        rom_im_q,
   output logic                         resp_valid,
   input  logic                         resp_ready,
   output logic [ID_WIDTH-1:0]          resp_id,
   output logic [DATA_WIDTH-1:0]        resp_re,
   output logic [DATA_WIDTH-1:0]        resp_im,
   output logic                         resp_err
);

   localparam int unsigned K_MAX = (32'd1 << ADDR_WIDTH) + 32'd1;
   localparam logic [DATA_WIDTH-1:0] ONE      = DATA_WIDTH'(1) << (DATA_WIDTH - 2);
   localparam logic [DATA_WIDTH-1:0] NEG_ONE  = DATA_WIDTH'(0) - ONE;
   localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [DATA_WIDTH-1:0] MOST_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } state_e;

   state_e                 state_q, state_d;
   logic [ID_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
   logic [ID_WIDTH-1:0]    id_q, id_d;
   logic [K_WIDTH-1:0]     k_q, k_d;
   logic                   inv_q, inv_d;
   logic [ADDR_WIDTH-1:0]  rom_addr_q, rom_addr_d;
   logic                   resp_valid_q, resp_valid_d;
   logic [ID_WIDTH-1:0]    resp_id_q, resp_id_d;
   logic [DATA_WIDTH-1:0]  resp_re_q, resp_re_d;
   logic [DATA_WIDTH-1:0]  resp_im_q, resp_im_d;
   logic                   resp_err_q, resp_err_d;

   logic                   gnt_found;
   logic [NUM_REQ-1:0]     gnt_vec;
   logic [ID_WIDTH-1:0]    gnt_id;
   logic [K_WIDTH-1:0]     sel_k;
   logic                   sel_inv;

   logic [DATA_WIDTH-1:0]  res_re;
   logic [DATA_WIDTH-1:0]  res_im_raw;
   logic [DATA_WIDTH-1:0]  res_im;
   logic                   res_err;

   // Round-robin scan: indices above rr_ptr first, then wrap to 0..rr_ptr
   always_comb begin
      gnt_found = 1'b0;
      gnt_vec   = '0;
      gnt_id    = '0;
      sel_k     = '0;
      sel_inv   = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!gnt_found && req_valid[i] && (i > 32'(rr_ptr_q))) begin
            gnt_found  = 1'b1;
            gnt_vec[i] = 1'b1;
            gnt_id     = ID_WIDTH'(i);
            sel_k      = req_k[i*K_WIDTH +: K_WIDTH];
            sel_inv    = req_inv[i];
         end
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!gnt_found && req_valid[i] && (i <= 32'(rr_ptr_q))) begin
            gnt_found  = 1'b1;
            gnt_vec[i] = 1'b1;
            gnt_id     = ID_WIDTH'(i);
            sel_k      = req_k[i*K_WIDTH +: K_WIDTH];
            sel_inv    = req_inv[i];
         end
      end
   end

   assign req_ready = (nreset && (state_q == IDLE)) ? gnt_vec : '0;

   // Coefficient selection and saturating conjugate, consumed when leaving CAPTURE
   always_comb begin
      res_re     = ONE;
      res_im_raw = '0;
      res_err    = 1'b0;
      if (k_q == K_WIDTH'(0)) begin
         res_re = ONE;
      end else if (k_q == K_WIDTH'(1)) begin
         res_re = NEG_ONE;
      end else if (32'(k_q) <= K_MAX) begin
         res_re     = rom_re_q;
         res_im_raw = rom_im_q;
      end else begin
         res_err = 1'b1;
      end

      if (inv_q) begin
         res_im = (res_im_raw == MOST_NEG) ? MOST_POS : (DATA_WIDTH'(0) - res_im_raw);
      end else begin
         res_im = res_im_raw;
      end
   end

   // Next-state and register updates
   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      id_d         = id_q;
      k_d          = k_q;
      inv_d        = inv_q;
      rom_addr_d   = rom_addr_q;
      resp_valid_d = resp_valid_q;
      resp_id_d    = resp_id_q;
      resp_re_d    = resp_re_q;
      resp_im_d    = resp_im_q;
      resp_err_d   = resp_err_q;

      case (state_q)
         IDLE: begin
            if (gnt_found) begin
               id_d       = gnt_id;
               k_d        = sel_k;
               inv_d      = sel_inv;
               rr_ptr_d   = gnt_id;
               rom_addr_d = (sel_k < K_WIDTH'(2)) ? '0 : ADDR_WIDTH'(sel_k - K_WIDTH'(2));
               state_d    = FETCH;
            end
         end
         FETCH: begin
            state_d = CAPTURE;
         end
         CAPTURE: begin
            resp_valid_d = 1'b1;
            resp_id_d    = id_q;
            resp_re_d    = res_re;
            resp_im_d    = res_im;
            resp_err_d   = res_err;
            state_d      = RESP;
         end
         RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q      <= IDLE;
         rr_ptr_q     <= ID_WIDTH'(NUM_REQ - 1);
         id_q         <= '0;
         k_q          <= '0;
         inv_q        <= 1'b0;
         rom_addr_q   <= '0;
         resp_valid_q <= 1'b0;
         resp_id_q    <= '0;
         resp_re_q    <= '0;
         resp_im_q    <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         id_q         <= id_d;
         k_q          <= k_d;
         inv_q        <= inv_d;
         rom_addr_q   <= rom_addr_d;
         resp_valid_q <= resp_valid_d;
         resp_id_q    <= resp_id_d;
         resp_re_q    <= resp_re_d;
         resp_im_q    <= resp_im_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign rom_addr   = rom_addr_q;
   assign resp_valid = resp_valid_q;
   assign resp_id    = resp_id_q;
   assign resp_re    = resp_re_q;
   assign resp_im    = resp_im_q;
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_phase_rom_arbiter.sv
// Bench for phase_rom_arbiter: directed cases then randomized traffic against a
// behavioural model of grant order, coefficient selection and response timing.
module tb_phase_rom_arbiter;

   localparam int unsigned NR = 4;
   localparam int unsigned DW = 24;
   localparam int unsigned AW = 5;
   localparam int unsigned KW = 6;
   localparam int unsigned IW = 2;

   logic              clk = 1'b0;
   logic              nreset;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_ready;
   logic [NR*KW-1:0]  req_k;
   logic [NR-1:0]     req_inv;
   logic [AW-1:0]     rom_addr;
   logic [DW-1:0]     rom_re_q;
   logic [DW-1:0]     rom_im_q;
   logic              resp_valid;
   logic              resp_ready;
   logic [IW-1:0]     resp_id;
   logic [DW-1:0]     resp_re;
   logic [DW-1:0]     resp_im;
   logic              resp_err;

   logic [DW-1:0]     rom_re_mem [32];
   logic [DW-1:0]     rom_im_mem [32];

   int                k_arr   [NR];
   bit                inv_arr [NR];
   int                rr_model;
   int                n_tests = 0;
   int                n_fail  = 0;

   always #5 clk = ~clk;

   phase_rom_arbiter #(
      .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .K_WIDTH(KW), .ID_WIDTH(IW)
   ) dut (
      .clk(clk), .nreset(nreset),
      .req_valid(req_valid), .req_ready(req_ready), .req_k(req_k), .req_inv(req_inv),
      .rom_addr(rom_addr), .rom_re_q(rom_re_q), .rom_im_q(rom_im_q),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_re(resp_re), .resp_im(resp_im), .resp_err(resp_err)
   );

   // Registered ROM pair, one cycle of latency
   always @(posedge clk) begin
      rom_re_q <= rom_re_mem[rom_addr];
      rom_im_q <= rom_im_mem[rom_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic int pick(input logic [NR-1:0] v);
      for (int off = 1; off <= int'(NR); off++) begin
         int i = (rr_model + off) % int'(NR);
         if (v[i]) return i;
      end
      return -1;
   endfunction

   function automatic void model(input int k, input bit inv,
                                 output logic [DW-1:0] re, output logic [DW-1:0] im,
                                 output bit err);
      int one;
      int rev;
      int imv;
      one = 1 << (DW - 2);
      err = 1'b0;
      imv = 0;
      if (k == 0) begin
         rev = one;
      end else if (k == 1) begin
         rev = -one;
      end else if (k <= (1 << AW) + 1) begin
         rev = $signed(rom_re_mem[k-2]);
         imv = $signed(rom_im_mem[k-2]);
      end else begin
         rev = one;
         err = 1'b1;
      end
      if (inv) begin
         imv = -imv;
         if (imv > (1 << (DW - 1)) - 1) imv = (1 << (DW - 1)) - 1;
      end
      re = DW'(rev);
      im = DW'(imv);
   endfunction

   task automatic drive();
      for (int i = 0; i < int'(NR); i++) begin
         req_k[i*KW +: KW] = KW'(k_arr[i]);
         req_inv[i]        = inv_arr[i];
      end
   endtask

   // Called at a settled point in an IDLE cycle; returns on the negedge after the accept
   task automatic run_txn(input int id, input int hold, input bit drop);
      logic [DW-1:0] e_re;
      logic [DW-1:0] e_im;
      bit            e_err;
      int            e_addr;
      model(k_arr[id], inv_arr[id], e_re, e_im, e_err);
      e_addr = (k_arr[id] < 2) ? 0 : (k_arr[id] - 2) % 32;
      chk("grant", 32'(req_ready), 32'(1) << id);
      resp_ready = (hold == 0);
      @(posedge clk);
      @(negedge clk);
      chk("fetch_addr", 32'(rom_addr), 32'(e_addr));
      chk("fetch_valid", 32'(resp_valid), 0);
      chk("fetch_ready", 32'(req_ready), 0);
      if (drop) req_valid[id] = 1'b0;
      @(negedge clk);
      chk("capture_valid", 32'(resp_valid), 0);
      chk("capture_ready", 32'(req_ready), 0);
      @(negedge clk);
      chk("resp_valid", 32'(resp_valid), 1);
      chk("resp_id", 32'(resp_id), 32'(id));
      chk("resp_re", 32'(resp_re), 32'(e_re));
      chk("resp_im", 32'(resp_im), 32'(e_im));
      chk("resp_err", 32'(resp_err), 32'(e_err));
      for (int c = 0; c < hold; c++) begin
         @(negedge clk);
         chk("hold_valid", 32'(resp_valid), 1);
         chk("hold_id", 32'(resp_id), 32'(id));
         chk("hold_re", 32'(resp_re), 32'(e_re));
         chk("hold_im", 32'(resp_im), 32'(e_im));
         chk("hold_err", 32'(resp_err), 32'(e_err));
         chk("hold_ready", 32'(req_ready), 0);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      chk("accepted", 32'(resp_valid), 0);
      rr_model = id;
   endtask

   initial begin
      nreset     = 1'b0;
      req_valid  = '0;
      req_k      = '0;
      req_inv    = '0;
      resp_ready = 1'b0;
      rr_model   = NR - 1;
      for (int i = 0; i < 32; i++) begin
         rom_re_mem[i] = DW'($urandom);
         rom_im_mem[i] = DW'($urandom);
      end
      rom_re_mem[0]  = 24'h000000; rom_im_mem[0]  = 24'h400000;
      rom_re_mem[1]  = 24'h2D413D; rom_im_mem[1]  = 24'h2D413D;
      rom_re_mem[5]  = 24'h123456; rom_im_mem[5]  = 24'h800000;
      rom_re_mem[31] = 24'h3FFFFF; rom_im_mem[31] = 24'h000000;
      for (int i = 0; i < int'(NR); i++) begin
         k_arr[i]   = 2;
         inv_arr[i] = 1'b0;
      end
      drive();

      // Reset values, with a request pending to show req_ready is held low
      repeat (2) @(negedge clk);
      req_valid = 4'b0001;
      #1;
      chk("rst_rom_addr", 32'(rom_addr), 0);
      chk("rst_resp_valid", 32'(resp_valid), 0);
      chk("rst_resp_id", 32'(resp_id), 0);
      chk("rst_resp_re", 32'(resp_re), 0);
      chk("rst_resp_im", 32'(resp_im), 0);
      chk("rst_resp_err", 32'(resp_err), 0);
      chk("rst_req_ready", 32'(req_ready), 0);

      // Single request k=2, then conjugate k=3
      @(negedge clk);
      nreset = 1'b1;
      k_arr[0] = 2; inv_arr[0] = 1'b0; drive(); #1;
      run_txn(pick(req_valid), 0, 1'b1);
      req_valid = 4'b0001; k_arr[0] = 3; inv_arr[0] = 1'b1; drive(); #1;
      run_txn(pick(req_valid), 0, 1'b1);

      // Special indices, saturation and range boundaries
      req_valid = 4'b0010; k_arr[1] = 0;  inv_arr[1] = 1'b0; drive(); #1;
      run_txn(pick(req_valid), 0, 1'b1);
      req_valid = 4'b0010; k_arr[1] = 1;  inv_arr[1] = 1'b1; drive(); #1;
      run_txn(pick(req_valid), 0, 1'b1);
      req_valid = 4'b0100; k_arr[2] = 34; inv_arr[2] = 1'b0; drive(); #1;
      run_txn(pick(req_valid), 0, 1'b1);
      req_valid = 4'b1000; k_arr[3] = 7;  inv_arr[3] = 1'b1; drive(); #1;
      run_txn(pick(req_valid), 0, 1'b1);
      req_valid = 4'b0001; k_arr[0] = 33; inv_arr[0] = 1'b1; drive(); #1;
      run_txn(pick(req_valid), 0, 1'b1);
      req_valid = 4'b0010; k_arr[1] = 63; inv_arr[1] = 1'b1; drive(); #1;
      run_txn(pick(req_valid), 0, 1'b1);

      // Backpressure with a competing requester waiting
      req_valid = 4'b0101; k_arr[0] = 4; k_arr[2] = 9; inv_arr[0] = 1'b0; inv_arr[2] = 1'b1;
      drive(); #1;
      run_txn(pick(req_valid), 10, 1'b1);
      #1;
      run_txn(pick(req_valid), 0, 1'b1);

      // Reset while in FETCH abandons the fetch
      req_valid = 4'b0001; k_arr[0] = 5; drive(); #1;
      chk("pre_rst_grant", 32'(req_ready), 32'(1) << pick(req_valid));
      @(posedge clk);
      @(negedge clk);
      nreset    = 1'b0;
      req_valid = 4'b1111;
      #1;
      chk("midrst_valid", 32'(resp_valid), 0);
      chk("midrst_ready", 32'(req_ready), 0);
      @(negedge clk);
      nreset    = 1'b1;
      req_valid = 4'b0000;
      rr_model  = NR - 1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("no_resp_after_rst", 32'(resp_valid), 0);
      end
      req_valid = 4'b1010; k_arr[1] = 6; k_arr[3] = 8; drive(); #1;
      run_txn(pick(req_valid), 0, 1'b1);

      // Round-robin with every requester continuously valid
      @(negedge clk);
      nreset = 1'b0;
      @(negedge clk);
      nreset   = 1'b1;
      rr_model = NR - 1;
      for (int i = 0; i < int'(NR); i++) begin
         k_arr[i]   = 2 + i;
         inv_arr[i] = 1'b0;
      end
      drive();
      req_valid = 4'b1111;
      #1;
      for (int t = 0; t < 5; t++) begin
         run_txn(pick(req_valid), 0, 1'b0);
         #1;
      end

      // Randomized traffic
      for (int it = 0; it < 60; it++) begin
         int id;
         req_valid = NR'($urandom_range(0, 15));
         for (int i = 0; i < int'(NR); i++) begin
            k_arr[i]   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(34, 63))
                                                     : int'($urandom_range(0, 33));
            inv_arr[i] = 1'($urandom_range(0, 1));
         end
         drive();
         #1;
         id = pick(req_valid);
         if (id < 0) begin
            chk("idle_no_grant", 32'(req_ready), 0);
            @(negedge clk);
         end else begin
            run_txn(id, int'($urandom_range(0, 3)), 1'b1);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
